// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
package imem_loader_pkg;

   typedef enum logic [2:0] {HDR, DATA, CSUM, DONE, ERR} state_t;

   localparam int HdrBytes  = 4;
   localparam int WordBytes = 4;
   localparam int CsumW     = 8;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-RAM write bus of the loader.
interface imem_loader_if #(
   parameter int AddrWidth = 10
);
   logic                 in_valid;
   logic                 in_ready;
   logic [7:0]           in_data;
   logic                 mem_we;
   logic [AddrWidth-1:0] mem_addr;
   logic [31:0]          mem_wdata;

   modport master (
      output in_valid, in_data,
      input  in_ready, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      input  in_valid, in_data,
      output in_ready, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/imem_loader_byte_packer.sv
// Assembles four bytes into a little-endian 32-bit word; word/word_valid are
// combinational so the consumer can act on the same edge as the 4th byte.
module byte_packer
   import imem_loader_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic        en,
   input  logic [7:0]  byte_in,
   output logic [31:0] word,
   output logic        word_valid
);

   logic [1:0]  cnt;
   logic [23:0] sh;

   // Newest byte enters at the top, so the first byte ends up in bits 7:0.
   assign word       = {byte_in, sh};
   assign word_valid = en && (cnt == 2'(WordBytes - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
         sh  <= '0;
      end else if (clear) begin
         cnt <= '0;
         sh  <= '0;
      end else if (en) begin
         cnt <= cnt + 2'd1;
         sh  <= word[31:8];
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Parses a length-prefixed byte stream, writes packed words to instruction RAM,
// verifies the trailing checksum and releases core_reset on success.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int          AddrWidth = 10,
   parameter int unsigned MaxWords  = 2**AddrWidth
) (
   input  logic           clk,
   input  logic           reset,
   imem_loader_if.slave   bus,
   output logic           core_reset,
   output logic           done,
   output logic           error
);

   localparam logic [31:0] MaxN = 32'(MaxWords);

   state_t               state, state_nxt;
   logic                 armed;
   logic                 accept;
   logic                 pk_en, pk_clear, pk_valid;
   logic [31:0]          pk_word;
   logic [AddrWidth:0]   n_words;
   logic [AddrWidth:0]   wcnt;
   logic [CsumW-1:0]     csum;
   logic                 last_word;

   assign accept    = bus.in_valid && bus.in_ready;
   assign pk_en     = accept && (state == HDR || state == DATA);
   assign pk_clear  = (state == HDR && pk_valid) || state == DONE || state == ERR;
   assign last_word = (wcnt + (AddrWidth+1)'(1)) == n_words;

   byte_packer u_packer (
      .clk        (clk),
      .reset      (reset),
      .clear      (pk_clear),
      .en         (pk_en),
      .byte_in    (bus.in_data),
      .word       (pk_word),
      .word_valid (pk_valid)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= HDR;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         HDR: if (pk_valid) begin
            if (pk_word > MaxN)      state_nxt = ERR;
            else if (pk_word == '0)  state_nxt = CSUM;
            else                     state_nxt = DATA;
         end
         DATA: if (pk_valid && last_word) state_nxt = CSUM;
         CSUM: if (accept) state_nxt = (bus.in_data == csum) ? DONE : ERR;
         default: state_nxt = state;
      endcase
   end

   // armed keeps in_ready low while reset is held and for the first cycle after.
   always_comb begin
      bus.in_ready = armed && (state == HDR || state == DATA || state == CSUM);
      core_reset   = (state != DONE);
      done         = (state == DONE);
      error        = (state == ERR);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         armed         <= 1'b0;
         n_words       <= '0;
         wcnt          <= '0;
         csum          <= '0;
         bus.mem_we    <= 1'b0;
         bus.mem_addr  <= '0;
         bus.mem_wdata <= '0;
      end else begin
         armed      <= 1'b1;
         bus.mem_we <= 1'b0;
         if (accept) begin
            case (state)
               HDR: if (pk_valid) begin
                  n_words <= pk_word[AddrWidth:0];
                  wcnt    <= '0;
                  csum    <= '0;
               end
               DATA: begin
                  csum <= csum + bus.in_data;
                  if (pk_valid) begin
                     bus.mem_we    <= 1'b1;
                     bus.mem_addr  <= wcnt[AddrWidth-1:0];
                     bus.mem_wdata <= pk_word;
                     wcnt          <= wcnt + (AddrWidth+1)'(1);
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Boot-time instruction-memory writer: the write-side counterpart of the core's read-only instruction fetch port. It accepts a byte stream (valid/ready), parses a length header, and packs payload bytes little-endian into 32-bit words. It writes those words to consecutive instruction RAM word addresses, then checks a trailing checksum. It holds the core in reset (`core_reset`) until a load completes successfully.

Parameters:
- `AddrWidth`, 10: instruction RAM word-address width; capacity is 2**AddrWidth words.
- `MaxWords`, 2**AddrWidth: largest accepted word count N.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  byte stream valid.
- `in_ready`  out  1  byte stream ready; a byte transfers when `in_valid && in_ready` on the rising edge of `clk`.
- `in_data`  in  8  stream byte.
- `mem_we`  out  1  instruction RAM write enable, one-cycle pulse per word.
- `mem_addr`  out  AddrWidth  word address of the write.
- `mem_wdata`  out  32  write data.
- `core_reset`  out  1  holds the core and its PC register in reset while high.
- `done`  out  1  load succeeded (sticky).
- `error`  out  1  load failed (sticky).

Behaviour:
- Reset values (asynchronous): `in_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `core_reset`=1, `done`=0, `error`=0; state=HDR; byte counter, word counter and checksum all 0.
- Stream format: 4 header bytes giving N (32-bit little-endian), then 4*N payload bytes, then 1 checksum byte.
  - The checksum byte must equal the 8-bit modular sum of the payload bytes only.
- State HDR: `in_ready`=1; shift each accepted byte into N, LSB first.
  - On the 4th header byte, if N > MaxWords: go to ERR.
  - Else if N == 0: go to CSUM.
  - Else: go to DATA.
- State DATA: `in_ready`=1; pack bytes little-endian (first byte -> bits 7:0) and add each byte to the checksum.
  - On the 4th byte of a word, the next cycle shows `mem_we`=1 for exactly one cycle, with `mem_addr` = word index and `mem_wdata` = packed word. Write latency is 1 cycle after the accepting edge.
  - Word index starts at 0 and increments per word. The word counter is AddrWidth+1 bits wide, so N == MaxWords writes addresses 0..MaxWords-1 with no wrap.
  - After word N-1 is accepted, go to CSUM. `in_ready` stays high during the write pulse; there is never a back-pressure bubble.
- State CSUM: `in_ready`=1; accept one byte.
  - If it matches the checksum: go to DONE.
  - Else: go to ERR.
- State DONE: `in_ready`=0, `done`=1, `core_reset`=0. `core_reset` falls on the edge after the checksum byte is accepted.
- State ERR: `in_ready`=0, `error`=1, `core_reset`=1.
- DONE and ERR are terminal; only `reset` leaves them.
- `in_valid` low in any state: hold all state; no counters advance.
- Reset mid-load: all outputs and state return to reset values. Words already written stay in RAM but are never trusted; the next load restarts at HDR and address 0.
- `mem_addr` and `mem_wdata` hold their last values when `mem_we`=0.

Decomposition:
- Package `imem_loader_pkg`:
  - state enum `{HDR, DATA, CSUM, DONE, ERR}`;
  - `HdrBytes`=4, `WordBytes`=4;
  - checksum width constant 8.
- Sub-module `byte_packer`:
  - 2-bit byte counter plus 32-bit little-endian shift assembly;
  - outputs `word` and a `word_valid` pulse;
  - clear input used for reset and between header and payload.
- The top-level FSM, counters and checksum live in `imem_loader`.

Test Plan:
- Single word: stream `01 00 00 00 EF BE AD DE 38` back-to-back -> one `mem_we` pulse with `mem_addr`=0 and `mem_wdata`=0xDEADBEEF; the next cycle after `38` shows `done`=1 and `core_reset`=0.
- Empty load: stream `00 00 00 00 00` -> no `mem_we`; `done`=1, `core_reset`=0, `in_ready`=0.
- Bad checksum: same as the single-word case but the checksum byte is `39` -> the write still occurs; then `error`=1, `core_reset` stays 1, `in_ready`=0; further `in_valid` is ignored.
- Oversize header (AddrWidth=10): `01 04 00 00` (N=0x401) -> `error`=1 the cycle after the 4th byte; no `mem_we` ever.
- Full fill with random `in_valid` gaps: N=0x400, data = word index -> 1024 pulses, last write at `mem_addr`=0x3FF with `mem_wdata`=0x3FF; result identical to the gap-free run; `done`=1.
- Reset mid-payload after 2 of 3 words -> outputs return to reset values immediately (async). A fresh 1-word load then writes `mem_addr`=0 and completes with `done`=1.
